// File: rtl/ram_dp_arbiter.sv
// Round-robin arbiter that shares one dual-port synchronous RAM between NCLI
// clients: up to two grants per cycle, same-address hazard blocking, read-data routing.
module ram_dp_arbiter #(
  parameter int NCLI = 4,
  parameter int AW   = 6,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCLI-1:0]    req,
  input  logic [NCLI-1:0]    we,
  input  logic [NCLI*AW-1:0] addr,
  input  logic [NCLI*DW-1:0] wdata,
  output logic [NCLI-1:0]    gnt,
  output logic [NCLI-1:0]    rvalid,
  output logic [NCLI*DW-1:0] rdata,
  output logic               ram_we_a,
  output logic [AW-1:0]      ram_addr_a,
  output logic [DW-1:0]      ram_din_a,
  input  logic [DW-1:0]      ram_dout_a,
  output logic               ram_we_b,
  output logic [AW-1:0]      ram_addr_b,
  output logic [DW-1:0]      ram_din_b,
  input  logic [DW-1:0]      ram_dout_b
);

  localparam int IW = (NCLI > 1) ? $clog2(NCLI) : 1;
  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    logic vld;
    logic rd;
    idx_t cli;
  } tag_t;

  function automatic idx_t wrap(input int v);
    return idx_t'(v % NCLI);
  endfunction

  logic [AW-1:0] cli_addr  [NCLI];
  logic [DW-1:0] cli_wdata [NCLI];

  for (genvar g = 0; g < NCLI; g++) begin : g_unpack
    assign cli_addr[g]  = addr[g*AW +: AW];
    assign cli_wdata[g] = wdata[g*DW +: DW];
  end

  logic [NCLI-1:0]    gnt_q, gnt_d;
  logic [NCLI-1:0]    rvalid_q, rvalid_d;
  logic [NCLI*DW-1:0] rdata_q, rdata_d;
  idx_t               ptr_q, ptr_d;
  logic               ram_we_a_q, ram_we_a_d, ram_we_b_q, ram_we_b_d;
  logic [AW-1:0]      ram_addr_a_q, ram_addr_a_d, ram_addr_b_q, ram_addr_b_d;
  logic [DW-1:0]      ram_din_a_q, ram_din_a_d, ram_din_b_q, ram_din_b_d;
  tag_t               tag_a1_q, tag_a1_d, tag_a2_q, tag_a2_d;
  tag_t               tag_b1_q, tag_b1_d, tag_b2_q, tag_b2_d;

  logic [NCLI-1:0]    elig;
  logic               a_vld, b_vld;
  idx_t               a_idx, b_idx;

  // A client that holds the grant this cycle is not eligible again until next cycle.
  assign elig = req & ~gnt_q;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    idx_t cand;
    cand  = '0;
    a_vld = 1'b0;
    a_idx = '0;
    b_vld = 1'b0;
    b_idx = '0;

    for (int k = 0; k < NCLI; k++) begin
      cand = wrap(int'(ptr_q) + k);
      if (!a_vld && elig[cand]) begin
        a_vld = 1'b1;
        a_idx = cand;
      end
    end

    // Port B continues the same circular scan, skipping anything that hazards with A.
    for (int k = 1; k < NCLI; k++) begin
      cand = wrap(int'(a_idx) + k);
      if (a_vld && !b_vld && elig[cand] &&
          !((cli_addr[cand] == cli_addr[a_idx]) && (we[cand] || we[a_idx]))) begin
        b_vld = 1'b1;
        b_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_d = '0;
    if (a_vld) gnt_d[a_idx] = 1'b1;
    if (b_vld) gnt_d[b_idx] = 1'b1;

    ptr_d = ptr_q;
    if (b_vld)      ptr_d = wrap(int'(b_idx) + 1);
    else if (a_vld) ptr_d = wrap(int'(a_idx) + 1);

    ram_we_a_d   = a_vld && we[a_idx];
    ram_addr_a_d = a_vld ? cli_addr[a_idx]  : ram_addr_a_q;
    ram_din_a_d  = a_vld ? cli_wdata[a_idx] : ram_din_a_q;
    ram_we_b_d   = b_vld && we[b_idx];
    ram_addr_b_d = b_vld ? cli_addr[b_idx]  : ram_addr_b_q;
    ram_din_b_d  = b_vld ? cli_wdata[b_idx] : ram_din_b_q;

    tag_a1_d = '{vld: a_vld, rd: a_vld && !we[a_idx], cli: a_idx};
    tag_b1_d = '{vld: b_vld, rd: b_vld && !we[b_idx], cli: b_idx};
    tag_a2_d = tag_a1_q;
    tag_b2_d = tag_b1_q;

    // Stage-2 tags line up with ram_dout; steer the data to its owner.
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tag_a2_q.vld && tag_a2_q.rd) begin
      rvalid_d[tag_a2_q.cli]              = 1'b1;
      rdata_d[int'(tag_a2_q.cli)*DW +: DW] = ram_dout_a;
    end
    if (tag_b2_q.vld && tag_b2_q.rd) begin
      rvalid_d[tag_b2_q.cli]              = 1'b1;
      rdata_d[int'(tag_b2_q.cli)*DW +: DW] = ram_dout_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q        <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      ptr_q        <= '0;
      ram_we_a_q   <= 1'b0;
      ram_addr_a_q <= '0;
      ram_din_a_q  <= '0;
      ram_we_b_q   <= 1'b0;
      ram_addr_b_q <= '0;
      ram_din_b_q  <= '0;
      tag_a1_q     <= '0;
      tag_a2_q     <= '0;
      tag_b1_q     <= '0;
      tag_b2_q     <= '0;
    end else begin
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      ptr_q        <= ptr_d;
      ram_we_a_q   <= ram_we_a_d;
      ram_addr_a_q <= ram_addr_a_d;
      ram_din_a_q  <= ram_din_a_d;
      ram_we_b_q   <= ram_we_b_d;
      ram_addr_b_q <= ram_addr_b_d;
      ram_din_b_q  <= ram_din_b_d;
      tag_a1_q     <= tag_a1_d;
      tag_a2_q     <= tag_a2_d;
      tag_b1_q     <= tag_b1_d;
      tag_b2_q     <= tag_b2_d;
    end
  end

  assign gnt        = gnt_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign ram_we_a   = ram_we_a_q;
  assign ram_addr_a = ram_addr_a_q;
  assign ram_din_a  = ram_din_a_q;
  assign ram_we_b   = ram_we_b_q;
  assign ram_addr_b = ram_addr_b_q;
  assign ram_din_b  = ram_din_b_q;

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Bench for ram_dp_arbiter: behavioural dual-port RAM, per-scenario tasks and a
// read-return scoreboard keyed by client.
module tb_ram_dp_arbiter;

  localparam int NCLI = 4;
  localparam int AW   = 6;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCLI-1:0]    req;
  logic [NCLI-1:0]    we;
  logic [NCLI*AW-1:0] addr;
  logic [NCLI*DW-1:0] wdata;
  logic [NCLI-1:0]    gnt;
  logic [NCLI-1:0]    rvalid;
  logic [NCLI*DW-1:0] rdata;
  logic               ram_we_a, ram_we_b;
  logic [AW-1:0]      ram_addr_a, ram_addr_b;
  logic [DW-1:0]      ram_din_a, ram_din_b;
  logic [DW-1:0]      ram_dout_a, ram_dout_b;

  ram_dp_arbiter #(.NCLI(NCLI), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_dout_a (ram_dout_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_din_b  (ram_din_b),
    .ram_dout_b (ram_dout_b)
  );

  always #5 clk = ~clk;

  // Behavioural RAM (read-old-data) and the bench's own record of intended contents.
  logic [DW-1:0] mem    [64];
  logic [DW-1:0] shadow [64];

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
  end

  typedef struct {
    int            cli;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Scoreboard: every rvalid pulse must match the oldest pending read of that client.
  always @(negedge clk) begin
    for (int i = 0; i < NCLI; i++) begin
      if (rvalid[i] === 1'b1) begin
        int hit;
        hit = -1;
        foreach (sb[j]) if (hit < 0 && sb[j].cli == i) hit = j;
        checks++;
        if (hit < 0) begin
          failures++;
          $display("FAIL sb_unexpected_rvalid client=%0d got=%h required=no_rvalid", i, rdata[i*DW +: DW]);
        end else begin
          if (rdata[i*DW +: DW] !== sb[hit].data) begin
            failures++;
            $display("FAIL sb_rdata client=%0d got=%h required=%h", i, rdata[i*DW +: DW], sb[hit].data);
          end
          sb.delete(hit);
        end
      end
    end
  end

  task automatic set_req(input int c, input logic w, input int a, input int d);
    req[c]             = 1'b1;
    we[c]              = w;
    addr[c*AW +: AW]   = AW'(a);
    wdata[c*DW +: DW]  = DW'(d);
  endtask

  task automatic push_read(input int c, input int a);
    exp_t e;
    e.cli  = c;
    e.data = shadow[a];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_port(input string name, input logic we_got, input logic [AW-1:0] a_got,
                          input logic [DW-1:0] d_got, input logic we_exp, input int a_exp,
                          input int d_exp, input bit chk_data);
    checks++;
    if (we_got !== we_exp || a_got !== AW'(a_exp) || (chk_data && d_got !== DW'(d_exp))) begin
      failures++;
      $display("FAIL %s got we=%b addr=%0d din=%h required we=%b addr=%0d din=%h",
               name, we_got, a_got, d_got, we_exp, a_exp, DW'(d_exp));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '1;
    we  = '0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (n == 1) begin
        rst = 1'b0;
        req = '0;
      end
      checks++;
      if (gnt !== '0 || rvalid !== '0 || ram_we_a !== 1'b0 || ram_we_b !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got gnt=%b rvalid=%b we_a=%b we_b=%b required all 0",
                 n, gnt, rvalid, ram_we_a, ram_we_b);
      end
    end
  endtask

  task automatic test_two_writes();
    set_req(0, 1'b1, 3, 8'hA5);
    set_req(2, 1'b1, 9, 8'h5A);
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b0101) begin
      failures++;
      $display("FAIL two_writes_gnt got=%b required=0101", gnt);
    end
    chk_port("two_writes_port_a", ram_we_a, ram_addr_a, ram_din_a, 1'b1, 3, 8'hA5, 1'b1);
    chk_port("two_writes_port_b", ram_we_b, ram_addr_b, ram_din_b, 1'b1, 9, 8'h5A, 1'b1);
    shadow[3] = 8'hA5;
    shadow[9] = 8'h5A;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || ram_we_a !== 1'b0 || ram_we_b !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_write got gnt=%b we_a=%b we_b=%b required 0", gnt, ram_we_a, ram_we_b);
    end
    chk_port("idle_hold_port_a", ram_we_a, ram_addr_a, ram_din_a, 1'b0, 3, 8'hA5, 1'b1);
  endtask

  task automatic test_read_back();
    set_req(1, 1'b0, 3, 0);
    set_req(3, 1'b0, 9, 0);
    push_read(1, 3);
    push_read(3, 9);
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b1010) begin
      failures++;
      $display("FAIL read_back_gnt got=%b required=1010", gnt);
    end
    // Pointer is 3 after the writes, so client 3 owns port A.
    chk_port("read_back_port_a", ram_we_a, ram_addr_a, ram_din_a, 1'b0, 9, 0, 1'b0);
    chk_port("read_back_port_b", ram_we_b, ram_addr_b, ram_din_b, 1'b0, 3, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (rvalid !== '0) begin
      failures++;
      $display("FAIL read_back_early got rvalid=%b required=0000", rvalid);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b1010 || rdata[1*DW +: DW] !== 8'hA5 || rdata[3*DW +: DW] !== 8'h5A) begin
      failures++;
      $display("FAIL read_back_data got rvalid=%b r1=%h r3=%h required rvalid=1010 r1=a5 r3=5a",
               rvalid, rdata[1*DW +: DW], rdata[3*DW +: DW]);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== '0 || rdata[1*DW +: DW] !== 8'hA5) begin
      failures++;
      $display("FAIL rdata_hold got rvalid=%b r1=%h required rvalid=0000 r1=a5", rvalid, rdata[1*DW +: DW]);
    end
  endtask

  task automatic test_write_conflict();
    do_reset();
    set_req(0, 1'b1, 5, 8'h11);
    set_req(1, 1'b1, 5, 8'h22);
    @(negedge clk);
    req[0] = 1'b0;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL conflict_gnt1 got=%b required=0001", gnt);
    end
    chk_port("conflict_port_a1", ram_we_a, ram_addr_a, ram_din_a, 1'b1, 5, 8'h11, 1'b1);
    checks++;
    if (ram_we_b !== 1'b0) begin
      failures++;
      $display("FAIL conflict_port_b_idle got we_b=%b required=0", ram_we_b);
    end
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL conflict_gnt2 got=%b required=0010", gnt);
    end
    chk_port("conflict_port_a2", ram_we_a, ram_addr_a, ram_din_a, 1'b1, 5, 8'h22, 1'b1);
    shadow[5] = 8'h22;
    @(negedge clk);
    set_req(2, 1'b0, 5, 0);
    push_read(2, 5);
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL conflict_read_gnt got=%b required=0100", gnt);
    end
    for (int n = 0; n < 10 && rvalid[2] !== 1'b1; n++) @(negedge clk);
    checks++;
    if (rvalid[2] !== 1'b1) begin
      failures++;
      $display("FAIL conflict_read_timeout got rvalid=%b required rvalid[2]=1", rvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [NCLI-1:0] exp_gnt;
    do_reset();
    for (int c = 0; c < NCLI; c++) set_req(c, 1'b0, 10 + c, 0);
    for (int n = 0; n < 6; n++) begin
      exp_gnt = (n % 2 == 0) ? 4'b0011 : 4'b1100;
      for (int c = 0; c < NCLI; c++) if (exp_gnt[c]) push_read(c, 10 + c);
      @(negedge clk);
      if (n == 5) req = '0;
      checks++;
      if (gnt !== exp_gnt) begin
        failures++;
        $display("FAIL fairness_gnt step=%0d got=%b required=%b", n, gnt, exp_gnt);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_read_read_same();
    do_reset();
    set_req(0, 1'b0, 7, 0);
    set_req(1, 1'b0, 7, 0);
    push_read(0, 7);
    push_read(1, 7);
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b0011 || ram_addr_a !== AW'(7) || ram_addr_b !== AW'(7)) begin
      failures++;
      $display("FAIL rr_same_gnt got gnt=%b addr_a=%0d addr_b=%0d required gnt=0011 addr_a=7 addr_b=7",
               gnt, ram_addr_a, ram_addr_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rvalid !== 4'b0011 || rdata[0 +: DW] !== shadow[7] || rdata[DW +: DW] !== shadow[7]) begin
      failures++;
      $display("FAIL rr_same_data got rvalid=%b r0=%h r1=%h required rvalid=0011 r0=r1=%h",
               rvalid, rdata[0 +: DW], rdata[DW +: DW], shadow[7]);
    end
    // Same request again, but reset lands right after the grant: the reads must vanish.
    set_req(0, 1'b0, 7, 0);
    set_req(1, 1'b0, 7, 0);
    @(negedge clk);
    req = '0;
    checks++;
    if (gnt !== 4'b0011) begin
      failures++;
      $display("FAIL rr_rst_gnt got=%b required=0011", gnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== '0) begin
        failures++;
        $display("FAIL rr_rst_dropped cycle=%0d got rvalid=%b required=0000", n, rvalid);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = DW'(i * 7 + 3);
      shadow[i] = DW'(i * 7 + 3);
    end
    test_reset();
    test_two_writes();
    test_read_back();
    test_write_conflict();
    test_fairness();
    test_read_read_same();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_pending got=%0d required=0 outstanding reads", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
